cdb_arbiter: RTL
================

# cdb_arbiter

- Parametrised common-data-bus arbiter for the out-of-order core.
- Sits between the result producers (ALU, d-cache load return, later FUs) and the ROB/reservation stations.
- Each producer gets a small skid FIFO with a valid/ready handshake. A round-robin grant moves up to NUM_BUS results per cycle onto NUM_BUS registered broadcast lanes.
- Replaces the single-lane, single-producer CDB with N sources and W lanes, backpressure and flush.

## Interface
Parameters:
- NUM_SRC, 2: number of producer channels (≥1)
- NUM_BUS, 1: number of CDB lanes (1 ≤ NUM_BUS ≤ NUM_SRC)
- TAG_WIDTH, ROB_DEPTH_BITS: ROB tag width
- DATA_WIDTH, 32: result width
- SKID_DEPTH, 2: per-source FIFO entries (≥1)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  mispredict/recovery flush, synchronous
- src_valid  in  NUM_SRC  producer result valid
- src_ready  out  NUM_SRC  FIFO can accept
- src_tag  in  NUM_SRC×TAG_WIDTH  packed, source i at [i*TAG_WIDTH +: TAG_WIDTH]
- src_data  in  NUM_SRC×DATA_WIDTH  packed likewise
- cdb_valid  out  NUM_BUS  lane broadcast valid
- cdb_tag  out  NUM_BUS×TAG_WIDTH  lane tag
- cdb_data  out  NUM_BUS×DATA_WIDTH  lane data

## Operation
- **Accept.** Source i is accepted on a rising edge when src_valid[i] && src_ready[i].
- **Ready.** src_ready[i] = (count_i < SKID_DEPTH). It depends only on registered state; there is no combinational path from src_valid.
- **Eligibility.** Source i is eligible when its FIFO is non-empty. Only its head entry can be granted.
- **Grant.** Scan sources from rr_ptr upward, modulo NUM_SRC. The first NUM_BUS eligible sources are granted.
  - Lane b carries the b-th granted source in scan order.
  - Ungranted lanes drive cdb_valid=0.
  - Tag and data on invalid lanes are don't-care but must hold their last value.
- **Pointer.** rr_ptr advances to (last granted source + 1) mod NUM_SRC. It is unchanged when nothing is granted.
  - Width is $clog2(NUM_SRC), minimum 1.
  - For non-power-of-two NUM_SRC, wrap must be explicit.
- **Dequeue.** Granted FIFOs dequeue on the same edge that loads the output registers.
- **Full FIFO with dequeue.** src_ready stays 0 that cycle. This is deliberate: no same-cycle refill.
- **Flush (highest priority).**
  - On the edge where flush=1: all FIFO counts go to 0, all cdb_valid go to 0, rr_ptr goes to 0.
  - Inputs presented that cycle are dropped, even if src_ready=1.
  - No grant is issued that cycle.
- **Reset.** Async assertion sets:
  - cdb_valid = 0
  - cdb_tag, cdb_data = 0
  - FIFO counts and pointers = 0
  - rr_ptr = 0
  - This makes src_ready all 1 combinationally.
- **FIFOs.** Each is a circular buffer. Read and write pointers wrap mod SKID_DEPTH; count width is $clog2(SKID_DEPTH+1).

## Timing
- cdb_* outputs are registered.
- Latency without bypass is 2 cycles: accepted at edge N, granted and visible after edge N+1.
- A result may sit in its FIFO indefinitely under contention. Round-robin guarantees a wait of at most ceil(NUM_SRC/NUM_BUS) grant cycles once the entry reaches the FIFO head.
- Each lane asserts valid for exactly one cycle per result. Consumers have no backpressure onto the CDB.

## Configuration
- CDB_ARBITER_BYPASS_EN defined:
  - A source with an empty FIFO and src_valid && src_ready is also eligible in that cycle.
  - If granted, its input goes straight to the output register and is not enqueued.
  - Latency drops to 1 cycle: visible after the accept edge.
  - If not granted, it is enqueued normally.
- Not defined: bypass logic is absent and latency is strictly 2 cycles.
- Flush behaviour is identical in both modes.

## Structure
- mips_core_pkg gains:
  - typedef cdb_entry_t {tag, data}
  - constants CDB_NUM_SRC and CDB_NUM_BUS, used by the top-level instantiation
- Sub-module cdb_skid_fifo:
  - one per source, parametrised by SKID_DEPTH and entry width
  - ports: push, pop, flush, head, count/full/empty
- The arbiter top holds the scan, rr_ptr and output registers.

## Test plan
- **Reset.** Reset with rst_n=0 mid-traffic. Expect cdb_valid=0, cdb_tag=0, src_ready=all 1 immediately, no stale result after release.
- **Single source, no bypass.** NUM_SRC=2, NUM_BUS=1. Src0 sends tag 5, data 0xDEADBEEF at edge N. Expect cdb_valid[0]=1 with tag 5 exactly after edge N+1, for one cycle. With BYPASS_EN, expect it after edge N.
- **Round-robin fairness.** NUM_SRC=3, NUM_BUS=1, all sources streaming continuously. Expect the grant order 0,1,2,0,1,2.
- **Lane fill, non-power-of-two wrap.** NUM_SRC=3, NUM_BUS=2, rr_ptr=2, all eligible. Expect lane0=src2, lane1=src0, rr_ptr→1.
- **Backpressure.** SKID_DEPTH=2, src1 blocked by contention. Expect src_ready[1]=0 after 2 accepts. Tags 7,8,9 offered; 9 is held by the producer until ready, and order 7,8,9 is preserved on the CDB.
- **Flush.** Assert flush with 2 entries queued, cdb_valid=1 and src_valid=1. Expect cdb_valid=0 next cycle, no queued or flush-cycle tag ever broadcast, src_ready all 1.

Source files
------------

// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared core types, including the CDB entry layout and the CDB arbiter configuration
package mips_core_pkg;
  localparam int ROB_DEPTH_BITS = 5;
  localparam int XLEN = 32;
  localparam int CDB_NUM_SRC = 2;
  localparam int CDB_NUM_BUS = 1;
  typedef struct packed {
    logic [ROB_DEPTH_BITS-1:0] tag;
    logic [XLEN-1:0] data;
  } cdb_entry_t;
  function automatic int ptr_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cdb_skid_fifo.sv
// cdb_skid_fifo: circular skid buffer holding one producer's results until the CDB grants them
module cdb_skid_fifo import mips_core_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = ptr_bits(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign head = mem[rd];
  assign empty = count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= inc(wr);
      if (pop) rd <= inc(rd);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter moving skid-buffered producer results onto NUM_BUS registered CDB lanes
// CDB_ARBITER_BYPASS_EN: an empty-FIFO producer may be granted straight from its inputs
module cdb_arbiter import mips_core_pkg::*; #(
  parameter int NUM_SRC = CDB_NUM_SRC,
  parameter int NUM_BUS = CDB_NUM_BUS,
  parameter int TAG_WIDTH = ROB_DEPTH_BITS,
  parameter int DATA_WIDTH = 32,
  parameter int SKID_DEPTH = 2,
  localparam int EW = TAG_WIDTH + DATA_WIDTH,
  localparam int PW = ptr_bits(NUM_SRC),
  localparam int CW = $clog2(SKID_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_SRC-1:0]            src_valid,
  output logic [NUM_SRC-1:0]            src_ready,
  input  logic [NUM_SRC*TAG_WIDTH-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_BUS-1:0]            cdb_valid,
  output logic [NUM_BUS*TAG_WIDTH-1:0]  cdb_tag,
  output logic [NUM_BUS*DATA_WIDTH-1:0] cdb_data
);
  logic [EW-1:0] head [NUM_SRC];
  logic [EW-1:0] cand [NUM_SRC];
  logic [CW-1:0] count [NUM_SRC];
  logic [NUM_SRC-1:0] empty, fast, elig, grant, push, pop;
  logic [NUM_BUS-1:0] lane_vld;
  logic [PW-1:0] lane_sel [NUM_BUS];
  logic [PW-1:0] rr_ptr, rr_nxt;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [EW-1:0] din;
    assign din = {src_tag[i*TAG_WIDTH +: TAG_WIDTH], src_data[i*DATA_WIDTH +: DATA_WIDTH]};
    assign src_ready[i] = count[i] < CW'(SKID_DEPTH);
`ifdef CDB_ARBITER_BYPASS_EN
    assign fast[i] = empty[i] && src_valid[i];
    assign cand[i] = fast[i] ? din : head[i];
`else
    assign fast[i] = 1'b0;
    assign cand[i] = head[i];
`endif
    assign elig[i] = !empty[i] || fast[i];
    // a bypassed grant consumes the input directly, so it must not also be enqueued
    assign push[i] = src_valid[i] && src_ready[i] && !flush && !(grant[i] && fast[i]);
    assign pop[i] = grant[i] && !empty[i];
    cdb_skid_fifo #(.DEPTH(SKID_DEPTH), .WIDTH(EW)) u_fifo (
      .clk(clk), .rst_n(rst_n), .flush(flush), .push(push[i]), .pop(pop[i]),
      .din(din), .head(head[i]), .count(count[i]), .empty(empty[i])
    );
  end
  always_comb begin
    logic [PW:0] s;
    logic [PW-1:0] idx;
    int n;
    grant = '0;
    lane_vld = '0;
    rr_nxt = rr_ptr;
    n = 0;
    for (int b = 0; b < NUM_BUS; b++) lane_sel[b] = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      s = {1'b0, rr_ptr} + (PW+1)'(k);
      idx = s >= (PW+1)'(NUM_SRC) ? PW'(s - (PW+1)'(NUM_SRC)) : PW'(s);
      if (!flush && elig[idx] && n < NUM_BUS) begin
        grant[idx] = 1'b1;
        for (int b = 0; b < NUM_BUS; b++)
          if (b == n) begin
            lane_vld[b] = 1'b1;
            lane_sel[b] = idx;
          end
        rr_nxt = idx == PW'(NUM_SRC - 1) ? '0 : idx + 1'b1;
        n++;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cdb_valid <= '0;
      cdb_tag <= '0;
      cdb_data <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      cdb_valid <= '0;
      rr_ptr <= '0;
    end else begin
      cdb_valid <= lane_vld;
      rr_ptr <= rr_nxt;
      for (int b = 0; b < NUM_BUS; b++)
        if (lane_vld[b]) begin
          cdb_tag[b*TAG_WIDTH +: TAG_WIDTH] <= cand[lane_sel[b]][EW-1 -: TAG_WIDTH];
          cdb_data[b*DATA_WIDTH +: DATA_WIDTH] <= cand[lane_sel[b]][DATA_WIDTH-1:0];
        end
    end
endmodule
